switch_port_sink: RTL and testbench
===================================

// Module: switch_port_sink
// PURPOSE
// Link-side receiver for one switch output port: far end of the out/data_ready_out/packet_sent/credit_granted
// interface. Latches flits presented by the switch, buffers them per VC, hands them to a local consumer via
// valid/ready, and returns one credit per freed slot. Used as the remote node on switch port 1 in chiplet benches.
// PARAMETERS
// NUM_VCS      2   virtual channels; must match switch NUM_VCS
// DEPTH        8   flits per VC FIFO; must equal switch BUFFER_SIZE (switch starts with DEPTH credits/VC)
// PORTS
// clk             in   1          clock, all logic on rising edge
// n_rst           in   1          reset: synchronous, active-high (1 = reset)
// in_flit         in   flit_t     flit from switch out[p]; VC taken from in_flit.vc
// data_ready_in   in   1          switch data_ready_out[p]; each high cycle = one flit
// packet_sent     out  1          ack to switch packet_sent[p]; 1-cycle pulse per accepted flit
// credit_granted  out  NUM_VCS    to switch credit_granted[p]; bit v pulses 1 cycle per freed VC-v slot
// rx_flit         out  flit_t     head flit of selected VC
// rx_vc           out  clog2(NUM_VCS) VC of rx_flit (min width 1)
// rx_valid        out  1          rx_flit valid
// rx_ready        in   1          consumer accepts when rx_valid & rx_ready
// overflow        out  1          sticky: flit arrived for full VC
// BEHAVIOUR
// - Reset (n_rst=1 at edge): all FIFOs empty, counts 0, RR pointer 0; packet_sent=0, credit_granted=0,
//   rx_valid=0, rx_flit=0, rx_vc=0, overflow=0. Reset wins over any same-cycle push/pop; in-flight data dropped,
//   no credits returned for it (switch is reset together).
// - Push: cycle N data_ready_in=1 -> in_flit written to FIFO[in_flit.vc] at edge N; packet_sent=1 in N+1.
// - Back-to-back pushes every cycle supported; packet_sent then high continuously, one pulse-cycle per flit.
// - Push to VC v accepted iff count[v]<DEPTH, or count[v]==DEPTH and VC v popped same cycle.
//   Otherwise flit dropped, overflow set (sticky until reset), packet_sent still pulsed, count unchanged.
// - in_flit.vc >= NUM_VCS: flit dropped, overflow set.
// - Output select (registered): state per VC; rx_valid/rx_flit/rx_vc are registered from the RR winner among
//   non-empty VCs, starting search at RR pointer. Pop when rx_valid & rx_ready; RR pointer -> popped VC+1 (wrap).
// - Latency: flit written at edge N to empty VC, consumer idle -> rx_valid=1 in N+1 (no earlier).
// - rx_flit/rx_vc stable while rx_valid & !rx_ready; never switch VC mid-stall.
// - After pop at edge M: credit_granted[rx_vc]=1 in cycle M+1 only; next head presented in M+1 if available
//   (full throughput 1 flit/cycle across VCs and within one VC).
// - Simultaneous push & pop same VC: count unchanged, both take effect, credit still returned.
// - Pointers: rd/wr index width clog2(DEPTH), wrap DEPTH-1 -> 0 (DEPTH need not be power of 2);
//   count width clog2(DEPTH+1).
// - Invariant: credits outstanding at switch + count[v] + (pending credit pulse) == DEPTH.
// TESTING
// 1 Reset: hold n_rst=1 2 cycles with data_ready_in=1 -> all outputs 0, no packet_sent, FIFOs empty.
// 2 Single flit VC1 payload 0xA5 at cycle 5, rx_ready=1 -> packet_sent=1 @6, rx_valid/rx_vc=1 @6,
//   credit_granted=2'b10 @7 only.
// 3 Fill VC0 with 8 flits 0..7, rx_ready=0 -> rx_valid=1 holding flit 0, overflow=0; 9th flit -> overflow=1,
//   dropped; drain -> flits 0..7 in order, exactly 8 credit_granted[0] pulses.
// 4 VC0 and VC1 each loaded with 3 flits, rx_ready=1 -> output order VC0,VC1,VC0,VC1,VC0,VC1, 1 flit/cycle.
// 5 VC0 full, push VC0 and pop VC0 same cycle -> accepted, count stays 8, overflow=0, one credit pulse.
// 6 Reset asserted with 4 flits buffered, rx_valid=1 -> next cycle rx_valid=0, no credit pulses; new flit
//   after reset delivered normally.

Source files
------------

// File: rtl/switch_port_sink.sv
// rtl/switch_port_sink.sv - link-side receiver for one switch output port: per-VC FIFOs, RR output, credit return
package switch_port_sink_pkg;
    localparam int FLIT_VC_W      = 2;
    localparam int FLIT_PAYLOAD_W = 32;

    typedef struct packed {
        logic [FLIT_VC_W-1:0]      vc;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;
endpackage

module switch_port_sink
    import switch_port_sink_pkg::*;
#(
    parameter  int NUM_VCS = 2,
    parameter  int DEPTH   = 8,
    localparam int VCW     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  flit_t              in_flit,
    input  logic               data_ready_in,
    output logic               packet_sent,
    output logic [NUM_VCS-1:0] credit_granted,
    output flit_t              rx_flit,
    output logic [VCW-1:0]     rx_vc,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               overflow
);

    flit_t              mem_q    [NUM_VCS][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_VCS];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_VCS];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_VCS];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_VCS];
    logic [CNT_W-1:0]   count_q  [NUM_VCS];
    logic [CNT_W-1:0]   count_d  [NUM_VCS];
    logic [VCW-1:0]     rr_q, rr_d;
    logic               rx_valid_q, rx_valid_d;
    flit_t              rx_flit_q, rx_flit_d;
    logic [VCW-1:0]     rx_vc_q, rx_vc_d;
    logic               packet_sent_q;
    logic [NUM_VCS-1:0] credit_q, credit_d;
    logic               overflow_q, overflow_d;

    logic               pop;
    logic               push_ok;
    logic               vc_in_range;
    logic [VCW-1:0]     push_vc;
    logic               sel_found;
    logic [VCW-1:0]     sel_vc;
    logic [VCW-1:0]     cand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop         = rx_valid_q & rx_ready;
        vc_in_range = 32'(in_flit.vc) < NUM_VCS;
        push_vc     = in_flit.vc[VCW-1:0];
        push_ok     = 1'b0;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        credit_d    = '0;

        // A full VC still takes the flit when its head leaves in the same cycle.
        if (data_ready_in) begin
            if (!vc_in_range) begin
                overflow_d = 1'b1;
            end else if (count_q[push_vc] < CNT_W'(DEPTH) || (pop && rx_vc_q == push_vc)) begin
                push_ok = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        for (int v = 0; v < NUM_VCS; v++) begin
            if (pop && rx_vc_q == VCW'(v)) begin
                credit_d[v] = 1'b1;
                rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            end
            if (push_ok && push_vc == VCW'(v)) begin
                wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
            end
            if (credit_d[v] && !(push_ok && push_vc == VCW'(v))) begin
                count_d[v] = count_q[v] - 1'b1;
            end else if (!credit_d[v] && push_ok && push_vc == VCW'(v)) begin
                count_d[v] = count_q[v] + 1'b1;
            end
        end

        rr_d = rr_q;
        if (pop) begin
            rr_d = (rx_vc_q == VCW'(NUM_VCS - 1)) ? '0 : rx_vc_q + 1'b1;
        end

        sel_found = 1'b0;
        sel_vc    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            cand = VCW'((int'(rr_d) + k) % NUM_VCS);
            if (!sel_found && count_d[cand] != '0) begin
                sel_found = 1'b1;
                sel_vc    = cand;
            end
        end

        rx_valid_d = rx_valid_q;
        rx_flit_d  = rx_flit_q;
        rx_vc_d    = rx_vc_q;
        // Output register only reloads when it is not stalled on the consumer.
        if (!(rx_valid_q && !rx_ready)) begin
            rx_valid_d = sel_found;
            if (sel_found) begin
                rx_vc_d = sel_vc;
                if (push_ok && push_vc == sel_vc && count_d[sel_vc] == CNT_W'(1)) begin
                    rx_flit_d = in_flit;
                end else begin
                    rx_flit_d = mem_q[sel_vc][rd_ptr_d[sel_vc]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            rr_q          <= '0;
            rx_valid_q    <= 1'b0;
            rx_flit_q     <= '0;
            rx_vc_q       <= '0;
            packet_sent_q <= 1'b0;
            credit_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rr_q          <= rr_d;
            rx_valid_q    <= rx_valid_d;
            rx_flit_q     <= rx_flit_d;
            rx_vc_q       <= rx_vc_d;
            packet_sent_q <= data_ready_in;
            credit_q      <= credit_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst && push_ok) begin
            mem_q[push_vc][wr_ptr_q[push_vc]] <= in_flit;
        end
    end

    assign packet_sent    = packet_sent_q;
    assign credit_granted = credit_q;
    assign rx_flit        = rx_flit_q;
    assign rx_vc          = rx_vc_q;
    assign rx_valid       = rx_valid_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_switch_port_sink.sv
// tb/tb_switch_port_sink.sv - directed and randomized checks of switch_port_sink against a queue model
module tb_switch_port_sink;
    import switch_port_sink_pkg::*;

    localparam int NV    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    flit_t         in_flit = '0;
    logic          data_ready_in = 1'b0;
    logic          packet_sent;
    logic [NV-1:0] credit_granted;
    flit_t         rx_flit;
    logic [0:0]    rx_vc;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    flit_t         mq [NV][$];
    logic          m_valid;
    logic [0:0]    m_vc;
    flit_t         m_flit;
    int            m_rr;
    logic          m_ps;
    logic [NV-1:0] m_credit;
    logic          m_ovf;

    switch_port_sink #(.NUM_VCS(NV), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .in_flit(in_flit), .data_ready_in(data_ready_in),
        .packet_sent(packet_sent), .credit_granted(credit_granted), .rx_flit(rx_flit),
        .rx_vc(rx_vc), .rx_valid(rx_valid), .rx_ready(rx_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic flit_t mk(input int vc, input int payload);
        flit_t f;
        f.vc      = 2'(vc);
        f.payload = 32'(payload);
        return f;
    endfunction

    task automatic model_edge(input logic dr, input flit_t f, input logic rdy, input logic rst);
        if (rst) begin
            for (int v = 0; v < NV; v++) mq[v].delete();
            m_valid = 0; m_vc = 0; m_flit = '0; m_rr = 0; m_ps = 0; m_credit = '0; m_ovf = 0;
        end else begin
            logic was_stalled;
            was_stalled = m_valid && !rdy;
            m_credit = '0;
            if (m_valid && rdy) begin
                void'(mq[m_vc].pop_front());
                m_credit[m_vc] = 1'b1;
                m_rr = (int'(m_vc) + 1) % NV;
            end
            m_ps = dr;
            if (dr) begin
                if (int'(f.vc) >= NV) m_ovf = 1;
                else if (mq[f.vc].size() < DEPTH) mq[f.vc].push_back(f);
                else m_ovf = 1;
            end
            if (!was_stalled) begin
                m_valid = 0;
                for (int k = NV - 1; k >= 0; k--) begin
                    int i;
                    i = (m_rr + k) % NV;
                    if (mq[i].size() > 0) begin
                        m_valid = 1; m_vc = 1'(i); m_flit = mq[i][0];
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic dr, input flit_t f, input logic rdy, input logic rst);
        n_rst = rst; data_ready_in = dr; in_flit = f; rx_ready = rdy;
        @(posedge clk);
        model_edge(dr, f, rdy, rst);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, mk(0, 32'h11), 1, 1);
        cyc(1, mk(1, 32'h22), 1, 1);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
        n_cmp++; if (packet_sent !== 1'b0) begin n_bad++; $display("FAIL reset_packet_sent: got %0b expected 0", packet_sent); end
        n_cmp++; if (credit_granted !== 2'b00) begin n_bad++; $display("FAIL reset_credit: got %0b expected 00", credit_granted); end
        n_cmp++; if (rx_flit !== flit_t'(0)) begin n_bad++; $display("FAIL reset_rx_flit: got %0h expected 0", rx_flit); end
        n_cmp++; if (rx_vc !== 1'b0) begin n_bad++; $display("FAIL reset_rx_vc: got %0b expected 0", rx_vc); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        cyc(0, '0, 0, 0);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_empty: got rx_valid %0b expected 0", rx_valid); end
    endtask

    task automatic test_single_flit();
        cyc(1, mk(1, 32'hA5), 1, 0);
        n_cmp++; if (packet_sent !== 1'b1) begin n_bad++; $display("FAIL single_packet_sent: got %0b expected 1", packet_sent); end
        n_cmp++; if (rx_valid !== 1'b1 || rx_vc !== 1'b1 || rx_flit.payload !== 32'hA5) begin
            n_bad++; $display("FAIL single_rx: got valid %0b vc %0b payload %0h expected 1 1 a5", rx_valid, rx_vc, rx_flit.payload); end
        n_cmp++; if (credit_granted !== 2'b00) begin n_bad++; $display("FAIL single_early_credit: got %0b expected 00", credit_granted); end
        cyc(0, '0, 1, 0);
        n_cmp++; if (credit_granted !== 2'b10) begin n_bad++; $display("FAIL single_credit: got %0b expected 10", credit_granted); end
        n_cmp++; if (packet_sent !== 1'b0 || rx_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_after: got ps %0b valid %0b expected 0 0", packet_sent, rx_valid); end
        cyc(0, '0, 1, 0);
        n_cmp++; if (credit_granted !== 2'b00) begin n_bad++; $display("FAIL single_credit_once: got %0b expected 00", credit_granted); end
    endtask

    task automatic test_fill_overflow();
        int popped, credits;
        cyc(0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, mk(0, i), 0, 0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_flit.payload !== 32'd0) begin
            n_bad++; $display("FAIL fill_head: got valid %0b payload %0h expected 1 0", rx_valid, rx_flit.payload); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_no_overflow: got %0b expected 0", overflow); end
        cyc(1, mk(0, 8), 0, 0);
        n_cmp++; if (overflow !== 1'b1 || packet_sent !== 1'b1) begin
            n_bad++; $display("FAIL fill_overflow: got ovf %0b ps %0b expected 1 1", overflow, packet_sent); end
        popped = 0; credits = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (rx_valid) begin
                n_cmp++; if (rx_flit.payload !== 32'(popped)) begin
                    n_bad++; $display("FAIL drain_order: got %0h expected %0h", rx_flit.payload, popped); end
                popped++;
            end
            cyc(0, '0, 1, 0);
            if (credit_granted[0]) credits++;
        end
        n_cmp++; if (popped != DEPTH || credits != DEPTH) begin
            n_bad++; $display("FAIL drain_counts: got %0d flits %0d credits expected 8 8", popped, credits); end
    endtask

    task automatic test_rr_interleave();
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, mk(0, 16 + i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, mk(1, 32 + i), 0, 0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_vc !== 1'(i % 2) || rx_flit.payload !== 32'((i % 2 ? 32 : 16) + i / 2)) begin
                n_bad++; $display("FAIL rr_order[%0d]: got valid %0b vc %0b payload %0h", i, rx_valid, rx_vc, rx_flit.payload); end
            cyc(0, '0, 1, 0);
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty: got %0b expected 0", rx_valid); end
    endtask

    task automatic test_full_push_pop();
        cyc(0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, mk(0, i), 0, 0);
        cyc(1, mk(0, 32'h99), 1, 0);
        n_cmp++; if (overflow !== 1'b0 || credit_granted !== 2'b01 || packet_sent !== 1'b1) begin
            n_bad++; $display("FAIL full_pushpop: got ovf %0b credit %0b ps %0b expected 0 01 1", overflow, credit_granted, packet_sent); end
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_flit.payload !== (i == DEPTH ? 32'h99 : 32'(i))) begin
                n_bad++; $display("FAIL full_drain[%0d]: got valid %0b payload %0h", i, rx_valid, rx_flit.payload); end
            cyc(0, '0, 1, 0);
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL full_count: got valid %0b expected 0", rx_valid); end
    endtask

    task automatic test_reset_midflight();
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, mk(i % 2, 64 + i), 0, 0);
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL mid_loaded: got %0b expected 1", rx_valid); end
        cyc(1, mk(0, 7), 1, 1);
        n_cmp++; if (rx_valid !== 1'b0 || credit_granted !== 2'b00 || packet_sent !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got valid %0b credit %0b ps %0b expected 0 00 0", rx_valid, credit_granted, packet_sent); end
        cyc(0, '0, 1, 0);
        n_cmp++; if (rx_valid !== 1'b0 || credit_granted !== 2'b00) begin
            n_bad++; $display("FAIL mid_after: got valid %0b credit %0b expected 0 00", rx_valid, credit_granted); end
        cyc(1, mk(1, 32'h5A), 1, 0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_vc !== 1'b1 || rx_flit.payload !== 32'h5A) begin
            n_bad++; $display("FAIL mid_new: got valid %0b vc %0b payload %0h expected 1 1 5a", rx_valid, rx_vc, rx_flit.payload); end
        cyc(0, '0, 1, 0);
        n_cmp++; if (credit_granted !== 2'b10) begin n_bad++; $display("FAIL mid_credit: got %0b expected 10", credit_granted); end
    endtask

    task automatic test_bad_vc();
        cyc(0, '0, 0, 1);
        cyc(1, mk(3, 32'h77), 1, 0);
        n_cmp++; if (overflow !== 1'b1 || packet_sent !== 1'b1 || rx_valid !== 1'b0) begin
            n_bad++; $display("FAIL bad_vc: got ovf %0b ps %0b valid %0b expected 1 1 0", overflow, packet_sent, rx_valid); end
    endtask

    task automatic test_random();
        int rdy_pct;
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 1200; i++) begin
            rdy_pct = ((i / 150) % 2 == 0) ? 20 : 90;
            cyc($urandom_range(99) < 75, mk($urandom_range(NV - 1), $urandom), $urandom_range(99) < rdy_pct, 0);
            n_cmp++;
            if (rx_valid !== m_valid || packet_sent !== m_ps || credit_granted !== m_credit || overflow !== m_ovf ||
                (m_valid && (rx_vc !== m_vc || rx_flit !== m_flit))) begin
                n_bad++;
                $display("FAIL random[%0d]: got v%0b vc%0b f%0h ps%0b cr%0b ov%0b expected v%0b vc%0b f%0h ps%0b cr%0b ov%0b",
                         i, rx_valid, rx_vc, rx_flit, packet_sent, credit_granted, overflow,
                         m_valid, m_vc, m_flit, m_ps, m_credit, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_fill_overflow();
        test_rr_interleave();
        test_full_push_pop();
        test_reset_midflight();
        test_bad_vc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
